// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush sequencer for the 5-stage pipeline: stalls, flushes, PC source select and mult/div hold.
// Define PIPE_IRQ_EN to enable interrupt entry (IRQ_ENTER state, EPC register, PCSrc=11).
module pipeline_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter logic [31:0] IRQ_VECTOR = 32'h80000004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_Jump,
  input  logic        ID_MulDiv,
  input  logic [31:0] ID_PC,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_BranchTaken,
  input  logic        IRQ,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_Flush,
  output logic        EX_Flush,
  output logic [1:0]  PCSrc,
  output logic [31:0] EPC
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
`ifdef PIPE_IRQ_EN
    IRQ_ENTER = 2'd2,
`endif
    MD_WAIT = 2'd1
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [2:0] r_mdCnt;
  logic [2:0] w_nextMdCnt;
  logic       w_loadUse;
  logic       w_unused;

  assign w_loadUse = EX_MemRead && (EX_Rt != 5'd0) &&
                     ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

`ifdef PIPE_IRQ_EN
  logic        w_irqAccept;
  logic        w_epcLoad;
  logic [31:0] r_epc;

  // The PC mux outside this block consumes IRQ_VECTOR; it is carried here for reference only.
  assign w_unused    = ^IRQ_VECTOR;
  assign w_irqAccept = IRQ && (ID_PC != 32'd0) && !ID_PC[31];
  assign EPC         = r_epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_epc <= 32'd0;
    end else if (w_epcLoad) begin
      r_epc <= ID_PC;
    end
  end
`else
  assign w_unused = ^{IRQ, ID_PC, IRQ_VECTOR};
  assign EPC      = 32'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_mdCnt <= 3'd0;
    end else begin
      r_state <= w_nextState;
      r_mdCnt <= w_nextMdCnt;
    end
  end

  // Only the highest-priority event in RUN acts; a deferred jump/IRQ is re-seen once the stall ends.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    ID_Flush    = 1'b0;
    EX_Flush    = 1'b0;
    PCSrc       = 2'b00;
    w_nextState = r_state;
    w_nextMdCnt = r_mdCnt;
`ifdef PIPE_IRQ_EN
    w_epcLoad   = 1'b0;
`endif
    case (r_state)
      RUN: begin
        if (EX_BranchTaken) begin
          ID_Flush = 1'b1;
          EX_Flush = 1'b1;
          PCSrc    = 2'b01;
`ifdef PIPE_IRQ_EN
        end else if (w_irqAccept) begin
          w_epcLoad   = 1'b1;
          ID_Flush    = 1'b1;
          EX_Flush    = 1'b1;
          PCSrc       = 2'b11;
          w_nextState = IRQ_ENTER;
`endif
        end else if (w_loadUse) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          EX_Flush    = 1'b1;
        end else if (ID_MulDiv) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          EX_Flush    = 1'b1;
          w_nextMdCnt = 3'(MD_LATENCY - 2);
          w_nextState = MD_WAIT;
        end else if (ID_Jump) begin
          ID_Flush = 1'b1;
          PCSrc    = 2'b10;
        end
      end
      MD_WAIT: begin
        if (r_mdCnt != 3'd0) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          EX_Flush    = 1'b1;
          w_nextMdCnt = r_mdCnt - 3'd1;
        end else begin
          w_nextState = RUN;
        end
      end
`ifdef PIPE_IRQ_EN
      IRQ_ENTER: begin
        w_nextState = RUN;
      end
`endif
      default: begin
        w_nextState = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a vector table plus hand sequences, checked via a scoreboard queue.
// Covers both builds; IRQ expectations depend on PIPE_IRQ_EN.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] DEF   = 6'b110000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] BR    = 6'b111101;
  localparam logic [5:0] JMP   = 6'b111010;
`ifdef PIPE_IRQ_EN
  localparam logic [5:0] IRQC  = 6'b111111;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UsesRt, ID_Jump, ID_MulDiv, EX_MemRead, EX_BranchTaken, IRQ;
  logic [31:0] ID_PC;
  logic        PC_Write, IF_ID_Write, ID_Flush, EX_Flush;
  logic [1:0]  PCSrc;
  logic [31:0] EPC;

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .IRQ_VECTOR(32'h80000004)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
    .ID_MulDiv(ID_MulDiv), .ID_PC(ID_PC), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .IRQ(IRQ),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_Flush(ID_Flush),
    .EX_Flush(EX_Flush), .PCSrc(PCSrc), .EPC(EPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br, irq, mr, usesRt, jump, md;
    logic [4:0]  rs, rt, exRt;
    logic [31:0] pc;
  } stim_t;

  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] epc;
    string       name;
  } exp_t;

  typedef struct {
    stim_t      s;
    logic [5:0] ctl;
    string      name;
  } vec_t;

  exp_t sbQ[$];
  int   errorCount = 0;
  int   checkCount = 0;

  function automatic stim_t st(input logic br, input logic irq, input logic mr,
                               input logic usesRt, input logic jump, input logic md,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] exRt, input logic [31:0] pc);
    stim_t s;
    s.br = br; s.irq = irq; s.mr = mr; s.usesRt = usesRt; s.jump = jump; s.md = md;
    s.rs = rs; s.rt = rt; s.exRt = exRt; s.pc = pc;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s, input logic [5:0] ctl,
                               input logic [31:0] epc, input string name);
    exp_t e;
    EX_BranchTaken = s.br;
    IRQ            = s.irq;
    EX_MemRead     = s.mr;
    ID_UsesRt      = s.usesRt;
    ID_Jump        = s.jump;
    ID_MulDiv      = s.md;
    ID_Rs          = s.rs;
    ID_Rt          = s.rt;
    EX_Rt          = s.exRt;
    ID_PC          = s.pc;
    e.ctl  = ctl;
    e.epc  = epc;
    e.name = name;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [5:0] act;
    @(negedge clk);
    checkCount++;
    if (sbQ.size() == 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard: no expected entry queued");
      return;
    end
    e   = sbQ.pop_front();
    act = {PC_Write, IF_ID_Write, ID_Flush, EX_Flush, PCSrc};
    if (act !== e.ctl || EPC !== e.epc) begin
      errorCount++;
      $display("[TB] FAIL %s: got ctl=%b epc=%h, expected ctl=%b epc=%h",
               e.name, act, EPC, e.ctl, e.epc);
    end
  endtask

  task automatic stepCycle(input stim_t s, input logic [5:0] ctl,
                           input logic [31:0] epc, input string name);
    applyStimulus(s, ctl, epc, name);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  vec_t  tbl[12];
  stim_t idle;
  logic [31:0] expEpc;

  initial begin
    idle = st(0,0,0,0,0,0, 5'd0,5'd0,5'd0, 32'd0);
    //               br irq mr uRt j md  rs     rt     exRt   pc
    tbl[0]  = '{st(0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 32'h0), DEF,   "idle"};
    tbl[1]  = '{st(0,0,1,0,0,0, 5'd5, 5'd0, 5'd5, 32'h0), STALL, "loadUseRs"};
    tbl[2]  = '{st(0,0,1,0,0,0, 5'd0, 5'd0, 5'd0, 32'h0), DEF,   "loadUseR0"};
    tbl[3]  = '{st(0,0,1,1,0,0, 5'd3, 5'd7, 5'd7, 32'h0), STALL, "loadUseRt"};
    tbl[4]  = '{st(0,0,1,0,0,0, 5'd3, 5'd7, 5'd7, 32'h0), DEF,   "rtNotUsed"};
    tbl[5]  = '{st(0,0,0,1,0,0, 5'd9, 5'd9, 5'd9, 32'h0), DEF,   "noMemRead"};
    tbl[6]  = '{st(1,0,0,0,1,0, 5'd0, 5'd0, 5'd0, 32'h0), BR,    "branchOverJump"};
    tbl[7]  = '{st(1,0,1,0,0,0, 5'd4, 5'd0, 5'd4, 32'h0), BR,    "branchOverLoadUse"};
    tbl[8]  = '{st(0,0,0,0,1,0, 5'd1, 5'd2, 5'd0, 32'h0), JMP,   "jump"};
    tbl[9]  = '{st(0,0,1,0,1,0, 5'd6, 5'd0, 5'd6, 32'h0), STALL, "loadUseOverJump"};
    tbl[10] = '{st(1,0,0,0,0,1, 5'd0, 5'd0, 5'd0, 32'h0), BR,    "branchOverMulDiv"};
    tbl[11] = '{st(0,0,0,0,1,0, 5'd0, 5'd0, 5'd3, 32'h0), JMP,   "jumpAfterBranch"};

    reset = 1'b0;
    applyStimulus(idle, DEF, 32'd0, "resetState");
    checkOutput();
    reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) stepCycle(tbl[i].s, tbl[i].ctl, 32'd0, tbl[i].name);

    // Mult/div: 3 stall cycles, jump ignored while held, released on the 4th; then back-to-back.
    stepCycle(st(0,0,0,0,0,1, 5'd0,5'd0,5'd0, 32'h0), STALL, 32'd0, "md1_stall1");
    stepCycle(st(0,0,1,0,1,1, 5'd2,5'd0,5'd2, 32'h0), STALL, 32'd0, "md1_stall2");
    stepCycle(st(0,0,0,0,0,1, 5'd0,5'd0,5'd0, 32'h0), STALL, 32'd0, "md1_stall3");
    stepCycle(st(0,0,0,0,1,1, 5'd0,5'd0,5'd0, 32'h0), DEF,   32'd0, "md1_release");
    stepCycle(st(0,0,0,0,0,1, 5'd0,5'd0,5'd0, 32'h0), STALL, 32'd0, "md2_stall1");
    stepCycle(st(0,0,0,0,0,1, 5'd0,5'd0,5'd0, 32'h0), STALL, 32'd0, "md2_stall2");
    stepCycle(st(0,0,0,0,0,1, 5'd0,5'd0,5'd0, 32'h0), STALL, 32'd0, "md2_stall3");
    stepCycle(st(0,0,0,0,0,1, 5'd0,5'd0,5'd0, 32'h0), DEF,   32'd0, "md2_release");
    stepCycle(st(0,0,0,0,1,0, 5'd0,5'd0,5'd0, 32'h0), JMP,   32'd0, "jumpAfterMd");

    // Interrupt entry, no re-entry from IRQ_ENTER, kernel-mode and bubble suppression.
    expEpc = 32'd0;
`ifdef PIPE_IRQ_EN
    stepCycle(st(0,1,0,0,0,0, 5'd0,5'd0,5'd0, 32'h00400010), IRQC, expEpc, "irqEnter");
    expEpc = 32'h00400010;
    stepCycle(st(0,1,0,0,0,0, 5'd0,5'd0,5'd0, 32'h00400014), DEF,  expEpc, "irqNoReentry");
    stepCycle(st(0,1,0,0,0,0, 5'd0,5'd0,5'd0, 32'h80000020), DEF,  expEpc, "irqKernel");
    stepCycle(st(0,1,0,0,0,0, 5'd0,5'd0,5'd0, 32'h00000000), DEF,  expEpc, "irqBubble");
    stepCycle(st(0,1,1,0,0,0, 5'd8,5'd0,5'd8, 32'h00400020), IRQC, expEpc, "irqOverLoadUse");
    expEpc = 32'h00400020;
    stepCycle(idle, DEF, expEpc, "irqEnter2");
    stepCycle(st(1,1,0,0,0,0, 5'd0,5'd0,5'd0, 32'h00400030), BR,   expEpc, "branchOverIrq");
    stepCycle(idle, DEF, expEpc, "afterBranchIrq");
`else
    stepCycle(st(0,1,0,0,0,0, 5'd0,5'd0,5'd0, 32'h00400010), DEF,   expEpc, "irqIgnored");
    stepCycle(st(0,1,0,0,1,0, 5'd0,5'd0,5'd0, 32'h00400014), JMP,   expEpc, "irqJumpActs");
    stepCycle(st(0,1,1,0,0,0, 5'd8,5'd0,5'd8, 32'h00400020), STALL, expEpc, "irqLoadUseActs");
    stepCycle(st(1,1,0,0,0,0, 5'd0,5'd0,5'd0, 32'h00400030), BR,    expEpc, "branchWithIrq");
`endif

    // Reset during the second mult/div stall cycle aborts straight to RUN.
    stepCycle(st(0,0,0,0,0,1, 5'd0,5'd0,5'd0, 32'h0), STALL, expEpc, "mdBeforeReset");
    reset = 1'b0;
    applyStimulus(idle, DEF, 32'd0, "mdResetAbort");
    checkOutput();
    @(posedge clk);
    #1;
    reset = 1'b1;
    stepCycle(idle, DEF, 32'd0, "postReset");
    stepCycle(st(0,0,0,0,1,0, 5'd0,5'd0,5'd0, 32'h0), JMP, 32'd0, "postResetJump");

    if (sbQ.size() != 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL scoreboardDrain: got %0d leftover entries, expected 0", sbQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
